// File: rtl/fir_pkg.sv
// Shared states, fixed-point widths and quantized low-pass taps for the
// decimating audio FIR stage.
package fir_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } fir_state_e;

  localparam int FIR_DATA_WIDTH  = 32;
  localparam int FIR_COEFF_WIDTH = 32;
  localparam int FIR_NUM_TAPS    = 32;
  localparam int FIR_DECIM       = 8;
  localparam int FIR_FRAC_BITS   = 10;
  localparam int FIR_PROD_WIDTH  = FIR_DATA_WIDTH + FIR_COEFF_WIDTH;

  // Symmetric low-pass response, Q(FRAC_BITS) fixed point.
  localparam logic signed [FIR_COEFF_WIDTH-1:0] AUDIO_LPR_COEFFS [FIR_NUM_TAPS] = '{
    -32'sd3,   -32'sd7,   -32'sd12,  -32'sd15,
    -32'sd11,   32'sd0,    32'sd20,   32'sd48,
     32'sd82,   32'sd118,  32'sd152,  32'sd181,
     32'sd204,  32'sd219,  32'sd228,  32'sd232,
     32'sd232,  32'sd228,  32'sd219,  32'sd204,
     32'sd181,  32'sd152,  32'sd118,  32'sd82,
     32'sd48,   32'sd20,   32'sd0,   -32'sd11,
    -32'sd15,  -32'sd12,  -32'sd7,   -32'sd3
  };

endpackage

// File: rtl/fir_mac.sv
// Single multiply-dequantize-accumulate lane: one tap per enabled cycle,
// wrapping accumulator, synchronous clear.
module fir_mac #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 32,
  parameter int FRAC_BITS   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic [DATA_WIDTH-1:0]  sample_i,
  input  logic [COEFF_WIDTH-1:0] coeff_i,
  output logic [DATA_WIDTH-1:0]  sum_o
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

  logic signed [PROD_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]        term;
  logic [DATA_WIDTH-1:0]        acc_q, acc_d;

  // Full-width signed product, arithmetic shift floors toward -inf.
  always_comb begin
    prod  = $signed({{COEFF_WIDTH{sample_i[DATA_WIDTH-1]}}, sample_i}) *
            $signed({{DATA_WIDTH{coeff_i[COEFF_WIDTH-1]}}, coeff_i});
    term  = DATA_WIDTH'(prod >>> FRAC_BITS);
    sum_o = acc_q + term;
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/audio_fir_decim.sv
// Decimating FIR low-pass: pops DECIM samples, runs a NUM_TAPS-cycle MAC,
// then pushes one filtered sample downstream.
module audio_fir_decim import fir_pkg::*; #(
  parameter int DATA_WIDTH  = FIR_DATA_WIDTH,
  parameter int COEFF_WIDTH = FIR_COEFF_WIDTH,
  parameter int NUM_TAPS    = FIR_NUM_TAPS,
  parameter int DECIM       = FIR_DECIM,
  parameter int FRAC_BITS   = FIR_FRAC_BITS,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = AUDIO_LPR_COEFFS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_fifo_empty,
  output logic                  in_rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  out_fifo_full,
  output logic                  wr_en_out,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  fir_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q [NUM_TAPS];
  logic [CNT_W-1:0]      decim_cnt_q, decim_cnt_d;
  logic [TAP_W-1:0]      tap_idx_q, tap_idx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  pop;
  logic                  mac_clear;
  logic                  mac_en;
  logic [DATA_WIDTH-1:0] mac_sum;
  logic [COEFF_WIDTH-1:0] coeff_sel;

  // Gated by reset so nothing is consumed while the block is held in reset.
  assign pop       = reset && (state_q == S_FILL) && !in_fifo_empty;
  assign in_rd_en  = pop;
  assign wr_en_out = (state_q == S_WRITE) && !out_fifo_full;
  assign dout      = dout_q;
  assign coeff_sel = COEFFS[tap_idx_q];

  always_comb begin
    state_d     = state_q;
    decim_cnt_d = decim_cnt_q;
    tap_idx_d   = tap_idx_q;
    dout_d      = dout_q;
    mac_clear   = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      S_FILL: begin
        if (pop) begin
          if (decim_cnt_q == CNT_LAST) begin
            decim_cnt_d = '0;
            tap_idx_d   = '0;
            mac_clear   = 1'b1;
            state_d     = S_MAC;
          end else begin
            decim_cnt_d = decim_cnt_q + CNT_W'(1);
          end
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (tap_idx_q == TAP_LAST) begin
          dout_d  = mac_sum;
          state_d = S_WRITE;
        end else begin
          tap_idx_d = tap_idx_q + TAP_W'(1);
        end
      end
      S_WRITE: begin
        if (wr_en_out) begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FILL;
      decim_cnt_q <= '0;
      tap_idx_q   <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      decim_cnt_q <= decim_cnt_d;
      tap_idx_q   <= tap_idx_d;
      dout_q      <= dout_d;
    end
  end

  // History survives across outputs; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else if (pop) begin
      x_q[0] <= din;
      for (int k = 1; k < NUM_TAPS; k++) begin
        x_q[k] <= x_q[k-1];
      end
    end
  end

  fir_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .FRAC_BITS   (FRAC_BITS)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (mac_clear),
    .en_i     (mac_en),
    .sample_i (x_q[tap_idx_q]),
    .coeff_i  (coeff_sel),
    .sum_o    (mac_sum)
  );

endmodule

// File: doc/audio_fir_decim.md
Name: audio_fir_decim

Overview:
- Decimating real FIR low-pass stage. Sits directly downstream of the FM demodulator.
- Pops 32-bit demodulated samples from the demod output FIFO and filters them with a fixed-coefficient, time-multiplexed single-MAC FIR.
- Pushes one filtered audio sample per DECIM input samples into its own output FIFO.
- Uses the same FIFO-side handshake (empty/rd_en in, full/wr_en out) as the demodulator.

Parameters:
- DATA_WIDTH, 32, sample and accumulator width (signed).
- COEFF_WIDTH, 32, coefficient width (signed, fixed-point).
- NUM_TAPS, 32, FIR length.
- DECIM, 8, decimation factor; NUM_TAPS must be a multiple of DECIM.
- FRAC_BITS, 10, fixed-point fraction bits of coefficients.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_fifo_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  pop upstream FIFO this cycle.
- din  in  DATA_WIDTH  upstream FIFO dout (first-word-fall-through; valid while !in_fifo_empty).
- out_fifo_full  in  1  downstream FIFO full.
- wr_en_out  out  1  push downstream FIFO this cycle.
- dout  out  DATA_WIDTH  filtered sample; valid when wr_en_out=1.

Behaviour:
- Reset (reset=0, async): state=S_FILL; sample shift register all 0; decim_cnt=0; tap_idx=0; accumulator=0; dout=0; in_rd_en=0; wr_en_out=0. All of this also applies to a reset asserted mid-MAC or mid-WRITE: the partial result is discarded and no write occurs.
- S_FILL:
  - in_rd_en = (state==S_FILL) && !in_fifo_empty (combinational).
  - On each pop: shift register shifts (x[k] <= x[k-1]), x[0] <= din, and decim_cnt increments.
  - On the pop where decim_cnt==DECIM-1: decim_cnt <= 0, accumulator <= 0, tap_idx <= 0, next state S_MAC.
  - in_fifo_empty=1 stalls with no state change.
- S_MAC:
  - One tap per cycle, for NUM_TAPS cycles: prod = x[tap_idx] * COEFFS[tap_idx], full 64-bit signed.
  - term = prod >>> FRAC_BITS (arithmetic, floor), truncated to DATA_WIDTH.
  - accumulator += term, modulo 2^DATA_WIDTH (wrap, no saturation).
  - After tap NUM_TAPS-1: dout <= final sum, next state S_WRITE.
  - in_rd_en=0 throughout.
- S_WRITE:
  - wr_en_out = (state==S_WRITE) && !out_fifo_full (combinational).
  - When asserted: next state S_FILL.
  - While out_fifo_full=1: dout held, no pops.
- Latency: the DECIM-th sample is popped in cycle t. The MAC runs in cycles t+1..t+NUM_TAPS. wr_en_out is asserted no earlier than t+NUM_TAPS+1.
- Throughput: one output per DECIM pops plus NUM_TAPS+1 cycles minimum.
- Filter history persists across outputs: the shift register is never cleared except by reset.
- First output is produced after DECIM samples; the taps hold zeros until filled.
- Simultaneous empty/full conditions cannot interact: reads and writes occur in disjoint states.

Decomposition:
- Package fir_pkg holds:
  - the state enum (S_FILL, S_MAC, S_WRITE);
  - the DEQUANTIZE width constants;
  - the localparam array AUDIO_LPR_COEFFS[NUM_TAPS] of signed 32-bit quantized coefficients.
- One sub-module is natural: fir_mac (registered multiply, shift, accumulate with clear/enable).
- Top-level wrapper audio_fir_top instantiates this block between two fifo instances, mirroring the demod top.

Test Plan:
- Impulse: din = 1024, then 39 zeros → outputs exactly COEFFS[7], COEFFS[15], COEFFS[23], COEFFS[31], then 0.
- Negative impulse: din = -1024, then zeros → outputs -COEFFS[7], -COEFFS[15], -COEFFS[23], -COEFFS[31].
- Floor dequantize: din = 1 and -1 against a test coefficient set of all 3 → per-term values 0 and -1 respectively; check sums.
- DC and latency: din constant 1024 → outputs 5 onward equal sum(COEFFS). wr_en_out is never earlier than 33 cycles after each 8th pop.
- Backpressure and stall:
  - Hold out_fifo_full=1 for 10 cycles in S_WRITE → wr_en_out=0, in_rd_en=0, dout stable; a single write follows on release.
  - Hold in_fifo_empty=1 mid-FILL → no pops, state unchanged.
- Reset mid-MAC: assert reset at tap 12 → all outputs 0 immediately, no write. After release, an impulse reproduces the first test's values from a clean history.
